// File: rtl/rx_fifo.sv
// UART receive FIFO: parity strip/check, FWFT storage, sticky errors, trigger and
// optional character-timeout (RX_TIMEOUT_EN) interrupts; all outputs registered.
module rx_fifo #(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [1:0]    i_word_length,
    input  logic          i_parity_en,
    input  logic          i_parity_even,
    input  logic [15:0]   i_baud_rate_cnt,
    input  logic [8:0]    i_rx_data,
    input  logic          i_rx_valid,
    input  logic          i_rd_en,
    input  logic          i_fifo_clr,
    input  logic          i_err_clr,
    input  logic [1:0]    i_trig_sel,
    output logic [7:0]    o_rd_data,
    output logic          o_rd_perr,
    output logic [AW:0]   o_count,
    output logic          o_empty,
    output logic          o_full,
    output logic          o_overrun,
    output logic          o_perr_any,
    output logic          o_int_trig,
    output logic          o_int_timeout
);
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   CNT_ONE = 1;
    localparam logic [AW:0]   CNT_FULL = DEPTH[AW:0];
    localparam logic [AW:0]   TRIG_4  = (DEPTH < 4)  ? DEPTH[AW:0] : 4;
    localparam logic [AW:0]   TRIG_8  = (DEPTH < 8)  ? DEPTH[AW:0] : 8;
    localparam logic [AW:0]   TRIG_14 = (DEPTH < 14) ? DEPTH[AW:0] : 14;

    logic [8:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_empty, r_full, r_overrun, r_perr_any, r_int_trig;
    logic [7:0]    r_rd_data;
    logic          r_rd_perr;

    logic [7:0]    w_mask, w_data;
    logic          w_par_bit, w_perr, w_rd, w_wr, w_ovr_set;
    logic [AW:0]   w_count_nxt, w_trig_lvl;
    logic [AW-1:0] w_rd_ptr_p1;

    assign w_mask      = 8'hFF >> (2'd3 - i_word_length);
    assign w_data      = i_rx_data[7:0] & w_mask;
    assign w_par_bit   = i_rx_data[4'd5 + {2'b00, i_word_length}];
    // XOR over data+parity is 0 for a good even-parity character, 1 for good odd
    assign w_perr      = i_parity_en & (^w_data ^ w_par_bit ^ ~i_parity_even);
    assign w_rd        = i_rd_en & ~r_empty;
    assign w_wr        = i_rx_valid & (~r_full | w_rd);
    assign w_ovr_set   = i_rx_valid & ~w_wr & ~i_fifo_clr;
    assign w_rd_ptr_p1 = r_rd_ptr + PTR_ONE;

    always_comb begin
        w_count_nxt = r_count;
        if (i_fifo_clr)
            w_count_nxt = '0;
        else if (w_wr && !w_rd)
            w_count_nxt = r_count + CNT_ONE;
        else if (!w_wr && w_rd)
            w_count_nxt = r_count - CNT_ONE;
    end

    always_comb begin
        case (i_trig_sel)
            2'b00:   w_trig_lvl = CNT_ONE;
            2'b01:   w_trig_lvl = TRIG_4;
            2'b10:   w_trig_lvl = TRIG_8;
            default: w_trig_lvl = TRIG_14;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (w_wr && !i_fifo_clr)
            r_mem[r_wr_ptr] <= {w_perr, w_data};
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_empty    <= 1'b1;
            r_full     <= 1'b0;
            r_overrun  <= 1'b0;
            r_perr_any <= 1'b0;
            r_int_trig <= 1'b0;
            r_rd_data  <= '0;
            r_rd_perr  <= 1'b0;
        end else begin
            if (i_fifo_clr) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_ONE;
                if (w_rd) r_rd_ptr <= w_rd_ptr_p1;
            end
            r_count    <= w_count_nxt;
            r_empty    <= (w_count_nxt == '0);
            r_full     <= (w_count_nxt == CNT_FULL);
            r_int_trig <= (w_count_nxt >= w_trig_lvl);
            if (w_ovr_set)
                r_overrun <= 1'b1;
            else if (i_err_clr)
                r_overrun <= 1'b0;
            if (w_wr && !i_fifo_clr && w_perr)
                r_perr_any <= 1'b1;
            else if (i_err_clr)
                r_perr_any <= 1'b0;
            // Head register tracks the entry that will be at the head next cycle
            if (!i_fifo_clr) begin
                if (w_wr && (r_empty || (w_rd && r_count == CNT_ONE))) begin
                    r_rd_data <= w_data;
                    r_rd_perr <= w_perr;
                end else if (w_rd && r_count > CNT_ONE) begin
                    r_rd_data <= r_mem[w_rd_ptr_p1][7:0];
                    r_rd_perr <= r_mem[w_rd_ptr_p1][8];
                end
            end
        end
    end

    assign o_rd_data  = r_rd_data;
    assign o_rd_perr  = r_rd_perr;
    assign o_count    = r_count;
    assign o_empty    = r_empty;
    assign o_full     = r_full;
    assign o_overrun  = r_overrun;
    assign o_perr_any = r_perr_any;
    assign o_int_trig = r_int_trig;

`ifdef RX_TIMEOUT_EN
    logic [15:0] r_bit_cnt;
    logic [5:0]  r_char_cnt;
    logic        r_int_timeout;
    logic        w_ev, w_cnt_en, w_tick;

    assign w_ev     = i_rx_valid | w_rd | i_fifo_clr;
    assign w_cnt_en = (i_baud_rate_cnt >= 16'd2);
    assign w_tick   = w_cnt_en && (r_bit_cnt >= i_baud_rate_cnt - 16'd1);

    // 40 bit periods = four 10-bit characters of silence
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_bit_cnt     <= '0;
            r_char_cnt    <= '0;
            r_int_timeout <= 1'b0;
        end else begin
            if (w_ev || r_empty) begin
                r_bit_cnt  <= '0;
                r_char_cnt <= '0;
            end else if (w_cnt_en) begin
                if (w_tick) begin
                    r_bit_cnt <= '0;
                    if (r_char_cnt != 6'd40) r_char_cnt <= r_char_cnt + 6'd1;
                end else begin
                    r_bit_cnt <= r_bit_cnt + 16'd1;
                end
            end
            if (w_ev)
                r_int_timeout <= 1'b0;
            else if (w_tick && !r_empty && r_char_cnt == 6'd39)
                r_int_timeout <= 1'b1;
        end
    end

    assign o_int_timeout = r_int_timeout;
`else
    logic w_unused;
    assign w_unused      = ^i_baud_rate_cnt;
    assign o_int_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_rx_fifo.sv
// Randomized bench for rx_fifo against a queue-based reference model.
module tb_rx_fifo;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  word_length;
    logic        parity_en, parity_even;
    logic [15:0] baud_rate_cnt;
    logic [8:0]  rx_data;
    logic        rx_valid, rd_en, fifo_clr, err_clr;
    logic [1:0]  trig_sel;
    logic [7:0]  rd_data;
    logic        rd_perr, empty, full, overrun, perr_any, int_trig, int_timeout;
    logic [4:0]  count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [8:0] q[$];
    logic [7:0] m_rd_data = 8'h00;
    logic       m_rd_perr = 1'b0;
    logic       m_ovr = 1'b0;
    logic       m_perr_any = 1'b0;

    always #5 clk = ~clk;

    rx_fifo #(.DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_rst(rst), .i_word_length(word_length),
        .i_parity_en(parity_en), .i_parity_even(parity_even),
        .i_baud_rate_cnt(baud_rate_cnt), .i_rx_data(rx_data),
        .i_rx_valid(rx_valid), .i_rd_en(rd_en), .i_fifo_clr(fifo_clr),
        .i_err_clr(err_clr), .i_trig_sel(trig_sel),
        .o_rd_data(rd_data), .o_rd_perr(rd_perr), .o_count(count),
        .o_empty(empty), .o_full(full), .o_overrun(overrun),
        .o_perr_any(perr_any), .o_int_trig(int_trig), .o_int_timeout(int_timeout)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Stored entry {perr, data} derived directly from the character format
    function automatic logic [8:0] ref_entry(input logic [8:0] rx, input int wl,
                                             input bit pen, input bit peven);
        int n = 5 + wl;
        int ones = 0;
        logic [7:0] d = 8'h00;
        bit perr;
        for (int i = 0; i < n; i++)
            if (rx[i]) begin d[i] = 1'b1; ones++; end
        ones += int'(rx[n]);
        perr = pen && ((ones % 2) != (peven ? 0 : 1));
        return {perr, d};
    endfunction

    function automatic int trig_level(input logic [1:0] sel);
        int lvl;
        case (sel)
            2'd0: lvl = 1;
            2'd1: lvl = 4;
            2'd2: lvl = 8;
            default: lvl = 14;
        endcase
        return (lvl > DEPTH) ? DEPTH : lvl;
    endfunction

    task automatic check_outputs();
        check("count", 32'(count), 32'(q.size()));
        check("empty", 32'(empty), 32'(q.size() == 0));
        check("full", 32'(full), 32'(q.size() == DEPTH));
        check("rd_data", 32'(rd_data), 32'(m_rd_data));
        check("rd_perr", 32'(rd_perr), 32'(m_rd_perr));
        check("overrun", 32'(overrun), 32'(m_ovr));
        check("perr_any", 32'(perr_any), 32'(m_perr_any));
        check("int_trig", 32'(int_trig), 32'(q.size() >= trig_level(trig_sel)));
`ifndef RX_TIMEOUT_EN
        check("int_timeout", 32'(int_timeout), 32'd0);
`endif
    endtask

    task automatic step(input bit v, input logic [8:0] d, input bit rd, input bit clr, input bit ec);
        logic [8:0] ent;
        bit did_rd, did_wr, ovr_set;
        @(negedge clk);
        rx_valid = v; rx_data = d; rd_en = rd; fifo_clr = clr; err_clr = ec;
        ent = ref_entry(d, int'(word_length), parity_en, parity_even);
        @(posedge clk);
        ovr_set = 1'b0;
        if (clr) begin
            q.delete();
        end else begin
            did_rd = rd && q.size() > 0;
            did_wr = v && (q.size() < DEPTH || did_rd);
            ovr_set = v && !did_wr;
            if (did_rd) void'(q.pop_front());
            if (did_wr) begin
                q.push_back(ent);
                if (ent[8]) m_perr_any = 1'b1;
                else if (ec) m_perr_any = 1'b0;
            end else if (ec) m_perr_any = 1'b0;
            if (q.size() > 0) begin
                m_rd_data = q[0][7:0];
                m_rd_perr = q[0][8];
            end
        end
        if (clr && ec) m_perr_any = 1'b0;
        if (ovr_set) m_ovr = 1'b1;
        else if (ec) m_ovr = 1'b0;
        #1;
        check_outputs();
        rx_valid = 1'b0; rd_en = 1'b0; fifo_clr = 1'b0; err_clr = 1'b0;
    endtask

    initial begin
        rst = 1'b1; word_length = 2'd3; parity_en = 1'b0; parity_even = 1'b1;
        baud_rate_cnt = 16'd4; rx_data = '0; rx_valid = 1'b0; rd_en = 1'b0;
        fifo_clr = 1'b0; err_clr = 1'b0; trig_sel = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        rst = 1'b0;

        // 8-bit, no parity
        step(1, 9'h1A5, 0, 0, 0);
        check("tp1_data", 32'(rd_data), 32'hA5);
        check("tp1_count", 32'(count), 32'd1);
        step(0, 9'h0, 1, 0, 0);

        // 5-bit, even parity, parity bit wrong
        word_length = 2'd0; parity_en = 1'b1; parity_even = 1'b1;
        step(1, 9'h015, 0, 0, 0);
        check("tp2_data", 32'(rd_data), 32'h15);
        check("tp2_perr", 32'(rd_perr), 32'd1);
        check("tp2_perr_any", 32'(perr_any), 32'd1);
        step(0, 9'h0, 1, 0, 1);

        // Overflow
        word_length = 2'd3; parity_en = 1'b0;
        for (int i = 0; i < 17; i++) step(1, 9'(i + 8'h30), 0, 0, 0);
        check("ovf_full", 32'(full), 32'd1);
        check("ovf_overrun", 32'(overrun), 32'd1);
        for (int i = 0; i < 16; i++) begin
            check("ovf_order", 32'(rd_data), 32'(i + 8'h30));
            step(0, 9'h0, 1, 0, 0);
        end
        step(0, 9'h0, 0, 0, 1);
        check("ovf_errclr", 32'(overrun), 32'd0);

        // Simultaneous write/read while full, then flush during a write
        for (int i = 0; i < 16; i++) step(1, 9'(i + 8'h40), 0, 0, 0);
        step(1, 9'h0EE, 1, 0, 0);
        check("full_rw_count", 32'(count), 32'd16);
        for (int i = 0; i < 16; i++) step(0, 9'h0, 1, 0, 0);
        check("full_rw_last", 32'(rd_data), 32'hEE);
        for (int i = 0; i < 5; i++) step(1, 9'(i), 0, 0, 0);
        step(1, 9'h077, 0, 1, 0);
        check("clr_count", 32'(count), 32'd0);
        check("clr_empty", 32'(empty), 32'd1);

        // Trigger level 4
        trig_sel = 2'd1;
        for (int i = 0; i < 3; i++) step(1, 9'(i + 1), 0, 0, 0);
        check("trig_3", 32'(int_trig), 32'd0);
        step(1, 9'h004, 0, 0, 0);
        check("trig_4", 32'(int_trig), 32'd1);
        step(0, 9'h0, 1, 0, 0);
        check("trig_rd", 32'(int_trig), 32'd0);
        step(0, 9'h0, 0, 1, 0);

`ifdef RX_TIMEOUT_EN
        begin
            int n = 0;
            baud_rate_cnt = 16'd4;
            step(1, 9'h05A, 0, 0, 0);
            while (int_timeout !== 1'b1 && n < 300) begin
                @(posedge clk); #1; n++;
            end
            check("timeout_cycles", 32'(n), 32'd160);
            step(0, 9'h0, 1, 0, 0);
            check("timeout_clr", 32'(int_timeout), 32'd0);
        end
`endif

        // Randomized traffic with phases biased toward filling and draining
        for (int c = 0; c < 3000; c++) begin
            bit v, rd, clr, ec;
            int wbias;
            if (c % 64 == 0) begin
                word_length = 2'($urandom_range(0, 3));
                parity_en   = 1'($urandom_range(0, 1));
                parity_even = 1'($urandom_range(0, 1));
                trig_sel    = 2'($urandom_range(0, 3));
            end
            wbias = ((c / 200) % 2 == 0) ? 80 : 30;
            v   = ($urandom_range(0, 99) < wbias);
            rd  = ($urandom_range(0, 99) < (110 - wbias) / 2);
            clr = ($urandom_range(0, 199) == 0);
            ec  = ($urandom_range(0, 19) == 0);
            step(v, 9'($urandom_range(0, 511)), rd, clr, ec);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
